// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial packed-BCD subtractor, diff = a - b.
// One decimal digit per clock, least-significant digit first, with
// valid/ready handshakes on both the operand and the result side.
// When borrow is set, diff holds the tens-complement of |a - b|.
//
// Optional build macro: BCD_SUB_DIGIT_CHECK_EN
//   defined   : err flags any operand nibble above 9, latched at accept
//   undefined : err is tied to 0 and no check logic is built
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready high
// ST_CALC | one digit of diff written per cycle, index 0..DIGITS-1
// ST_DONE | result presented, held until out_ready

module bcd_sub_serial #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  borrow,
   output logic                  err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [4*DIGITS-1:0]   a_q, a_d;
   logic [4*DIGITS-1:0]   b_q, b_d;
   logic [4*DIGITS-1:0]   diff_q, diff_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  br_q, br_d;
   logic                  borrow_q, borrow_d;

   logic                  accept;
   logic [3:0]            a_dig;
   logic [3:0]            b_dig;
   logic signed [5:0]     t_raw;
   logic signed [5:0]     t_adj;
   logic [3:0]            dig_res;
   logic                  dig_br;

   assign accept = in_valid && (state_q == ST_IDLE);

   // select the current digit of each latched operand
   always_comb begin
      a_dig = 4'd0;
      b_dig = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            a_dig = a_q[4*i +: 4];
            b_dig = b_q[4*i +: 4];
         end
      end
   end

   // per-digit subtract with decimal borrow; non-BCD digits pass uncorrected
   always_comb begin
      t_raw   = $signed({2'b00, a_dig}) - $signed({2'b00, b_dig})
                - $signed({5'b00000, br_q});
      t_adj   = t_raw + 6'sd10;
      dig_br  = t_raw[5];
      dig_res = dig_br ? t_adj[3:0] : t_raw[3:0];
   end

   // next-state and datapath update
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      idx_d    = idx_q;
      br_d     = br_q;
      borrow_d = borrow_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d      = a;
               b_d      = b;
               diff_d   = '0;
               idx_d    = '0;
               br_d     = 1'b0;
               borrow_d = 1'b0;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IW'(i)) begin
                  diff_d[4*i +: 4] = dig_res;
               end
            end
            br_d = dig_br;
            if (idx_q == LAST_IDX) begin
               // index stays put on the last digit so it never wraps
               borrow_d = dig_br;
               state_d  = ST_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         idx_q    <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         idx_q    <= idx_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
      end
   end

`ifdef BCD_SUB_DIGIT_CHECK_EN
   logic err_q, err_d;

   function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   // capture the operand check once, at accept
   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = has_bad_digit(a) || has_bad_digit(b);
      end
   end

   // error flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign diff      = diff_q;
   assign borrow    = borrow_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial: scoreboard bench for bcd_sub_serial (DIGITS=4).
// Expected results come from integer arithmetic on the decimal values.
// Build with +define+BCD_SUB_DIGIT_CHECK_EN to cover the digit check.

module tb_bcd_sub_serial;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  diff;
   logic          borrow;
   logic          err;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic rand_rdy = 1'b0;

`ifdef BCD_SUB_DIGIT_CHECK_EN
   localparam logic CHECK_ON = 1'b1;
`else
   localparam logic CHECK_ON = 1'b0;
`endif

   bcd_sub_serial #(.DIGITS(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   function automatic longint bcd2int(input logic [W-1:0] v);
      longint r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input longint n);
      logic [W-1:0] r = '0;
      longint m = n;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic bad_bcd(input logic [W-1:0] v);
      logic r = 1'b0;
      for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   // decimal reference: valid BCD operands only
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint p10 = 1;
      longint d;
      for (int i = 0; i < D; i++) p10 = p10 * 10;
      d        = bcd2int(x) - bcd2int(y);
      e.borrow = (d < 0);
      e.diff   = int2bcd((d < 0) ? d + p10 : d);
      e.err    = CHECK_ON && (bad_bcd(x) || bad_bcd(y));
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] r;
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   task automatic send(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input exp_t e, input bit push, input bit meas);
      int guard = 0;
      int k = 0;
      @(posedge clk); #1;
      a = ai;
      b = bi;
      in_valid = 1'b1;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 200) fail_now("accept_timeout");
      @(posedge clk);
      if (push) exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (meas) begin
         while (k < 50) begin
            @(posedge clk); #1;
            k++;
            if (out_valid) break;
         end
         chk("latency", 64'(k), 64'(D));
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 200) fail_now("idle_timeout");
   endtask

   // monitor: compare presented result with the scoreboard head every cycle
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_output");
            end else begin
               chk("diff", 64'(diff), 64'(exp_q[0].diff));
               chk("borrow", 64'(borrow), 64'(exp_q[0].borrow));
               chk("err", 64'(err), 64'(exp_q[0].err));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // random backpressure
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      exp_t e;
      int   guard;

      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_diff", 64'(diff), 64'd0);
      chk("rst_borrow", 64'(borrow), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic, single-cycle valid
      out_ready = 1'b1;
      send(16'h1234, 16'h0234, model(16'h1234, 16'h0234), 1, 1);
      @(posedge clk); #1;
      chk("valid_one_cycle", 64'(out_valid), 64'd0);
      chk("ready_after_hs", 64'(in_ready), 64'd1);

      send(16'h1000, 16'h0001, model(16'h1000, 16'h0001), 1, 1);
      send(16'h0000, 16'h0001, model(16'h0000, 16'h0001), 1, 1);
      send(16'h0250, 16'h0400, model(16'h0250, 16'h0400), 1, 1);

      // backpressure with ignored input pulses
      wait_idle();
      out_ready = 1'b0;
      send(16'h9999, 16'h9999, model(16'h9999, 16'h9999), 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         in_valid = 1'(i % 2);
         a = 16'h1111;
         b = 16'h2222;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready_after", 64'(in_ready), 64'd1);
      chk("bp_valid_after", 64'(out_valid), 64'd0);

      // reset mid-operation
      send(16'h5000, 16'h0001, model(16'h5000, 16'h0001), 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_diff", 64'(diff), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_borrow", 64'(borrow), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h0042, 16'h0017, model(16'h0042, 16'h0017), 1, 1);

      // digit check: invalid nibble flows through the digit rule unchanged
      e.diff   = 16'h00A0;
      e.borrow = 1'b0;
      e.err    = CHECK_ON;
      send(16'h00A0, 16'h0000, e, 1, 1);
      send(16'h0090, 16'h0000, model(16'h0090, 16'h0000), 1, 1);

      // randomized operands with random backpressure
      wait_idle();
      rand_rdy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = rand_bcd();
         rb = rand_bcd();
         send(ra, rb, model(ra, rb), 1, 1);
      end
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;

      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
